// File: rtl/membus_arb_pkg.sv
// membus_arb_pkg: shared FSM/owner types and the conflict-resolution helper for membus_arbiter.
package membus_arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
   typedef enum logic {OWNER_I, OWNER_D} owner_t;

   // With both valid: round robin favours the requester that was not granted last; otherwise d wins.
   function automatic owner_t pick_owner(input logic i_v, input logic d_v, input logic rr, input owner_t last);
      return (i_v && d_v) ? ((rr && last == OWNER_D) ? OWNER_I : OWNER_D) : (i_v ? OWNER_I : OWNER_D);
   endfunction

endpackage

// File: rtl/membus_if.sv
// membus_if: valid/ready request channel with a single-pulse rvalid response.
interface membus_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                    valid;
   logic                    ready;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    wen;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wmask;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
   modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/membus_arbiter.sv
// membus_arbiter: muxes instruction and data requesters onto one memory bus, one request in flight,
// zero added latency; a stalled grant stays locked to its owner until the memory accepts it.
module membus_arbiter
   import membus_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int ROUND_ROBIN = 1
) (
   input logic      clk,
   input logic      rst,
   membus_if.slave  i_membus,
   membus_if.slave  d_membus,
   membus_if.master membus
);

   localparam int MASK_W = DATA_WIDTH / 8;

   state_t                state_q, state_d;
   owner_t                last_q, last_d;
   owner_t                lock_owner_q, lock_owner_d;
   logic                  lock_q, lock_d;
   owner_t                owner;
   logic                  grant_pt;
   logic                  sel_valid;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [MASK_W-1:0]     sel_wmask;
   logic                  sel_wen;

   // A response cycle is also a grant point, so the next request issues with no bubble.
   assign grant_pt  = !rst && (state_q == IDLE || membus.rvalid);
   assign owner     = lock_q ? lock_owner_q
                             : pick_owner(i_membus.valid, d_membus.valid, ROUND_ROBIN != 0, last_q);
   assign sel_valid = owner == OWNER_I ? i_membus.valid : d_membus.valid;
   assign sel_addr  = owner == OWNER_I ? i_membus.addr  : d_membus.addr;
   assign sel_wdata = owner == OWNER_I ? i_membus.wdata : d_membus.wdata;
   assign sel_wmask = owner == OWNER_I ? i_membus.wmask : d_membus.wmask;
   assign sel_wen   = owner == OWNER_I ? i_membus.wen   : d_membus.wen;

   assign membus.valid = grant_pt && sel_valid;
   assign membus.addr  = sel_addr;
   assign membus.wdata = sel_wdata;
   assign membus.wmask = sel_wmask;
   assign membus.wen   = sel_wen;

   assign i_membus.ready  = grant_pt && owner == OWNER_I && membus.ready;
   assign d_membus.ready  = grant_pt && owner == OWNER_D && membus.ready;
   assign i_membus.rvalid = !rst && membus.rvalid && state_q == WAIT_I;
   assign d_membus.rvalid = !rst && membus.rvalid && state_q == WAIT_D;
   assign i_membus.rdata  = membus.rdata;
   assign d_membus.rdata  = membus.rdata;

   assign accept = membus.valid && membus.ready;

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
      if (accept) begin
         state_d = owner == OWNER_I ? WAIT_I : WAIT_D;
         last_d  = owner;
      end else if (membus.rvalid) begin
         state_d = IDLE;
      end
      if (membus.valid) begin
         lock_d       = !membus.ready;
         lock_owner_d = owner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_q       <= OWNER_I;
         lock_q       <= 1'b0;
         lock_owner_q <= OWNER_I;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
      end
   end

endmodule
